shift_engine: RTL and testbench
===============================

SHIFT_ENGINE -- requirements
Module: shift_engine

Interface
REQ-001 SHALL have parameter WIDTH, default 8, register width in bits; legal range 2..64.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port shift_en  input  1  serial-clock edge strobe; one-cycle pulse that qualifies each shift.
REQ-005 SHALL have port mode  input  2  manual op: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
REQ-006 SHALL have port parallel_in  input  WIDTH  parallel load value.
REQ-007 SHALL have port serial_in  input  1  bit inserted at the vacated end on every shift.
REQ-008 SHALL have port start  input  1  request an automatic WIDTH-bit transfer.
REQ-009 SHALL have port lsb_first  input  1  transfer order: 0 MSB-first, 1 LSB-first; sampled with start.
REQ-010 SHALL have port parallel_out  output  WIDTH  current register contents.
REQ-011 SHALL have port serial_out  output  1  outgoing bit: reg[WIDTH-1] when the direction bit is 0, reg[0] when it is 1.
REQ-012 SHALL have port busy  output  1  high while a transfer is in progress.
REQ-013 SHALL have port done  output  1  one-cycle pulse at transfer completion.
REQ-014 SHALL have port bit_count  output  $clog2(WIDTH+1)  number of shifts remaining in the current transfer.

Function
REQ-015 SHALL implement a two-state FSM: IDLE and XFER.
REQ-016 In IDLE, when start=0 and shift_en=1, SHALL apply mode: hold; right = {serial_in, reg[WIDTH-1:1]}; left = {reg[WIDTH-2:0], serial_in}; load = parallel_in.
REQ-017 In IDLE, when shift_en=0, SHALL hold the register regardless of mode.
REQ-018 In IDLE, when start=1, SHALL load parallel_in, latch lsb_first into the direction bit, set bit_count=WIDTH, and go to XFER; this takes priority over shift_en/mode in the same cycle, so no shift occurs that cycle.
REQ-019 In XFER, on each shift_en, SHALL shift left (MSB-first) or right (LSB-first) with serial_in filling the vacated end, and decrement bit_count.
REQ-020 In XFER, SHALL ignore mode, start and lsb_first; a start during XFER SHALL be dropped, not queued.
REQ-021 On the edge applying the shift that takes bit_count from 1 to 0, SHALL return to IDLE, deassert busy and assert done for exactly the following cycle.
REQ-022 busy SHALL equal (state==XFER), registered; done SHALL never coincide with busy=1.
REQ-023 In manual mode, the direction bit SHALL retain its last latched value, so serial_out follows it.
REQ-024 A start in the cycle in which done is high SHALL be accepted, giving back-to-back transfers with one idle cycle.
REQ-025 Transfer latency SHALL be 1 load cycle plus WIDTH shift_en strobes, independent of the strobe spacing.

Reset
REQ-026 With rst_n=0 at posedge clk: register=0, direction bit=0, bit_count=0, state=IDLE, busy=0, done=0, serial_out=0.
REQ-027 Reset SHALL abort any transfer in progress with no done pulse, and SHALL take priority over start and shift_en.

Structure
REQ-028 Mode encodings (HOLD, RIGHT, LEFT, PLOAD) and the FSM state encodings SHALL live in the shared mode package/include, replacing the standalone mode definitions.
REQ-029 The datapath SHALL be one sub-module, shift_core (WIDTH-parameterised register with a 4-op mux); shift_engine adds the FSM and the counter.

Verification (WIDTH=8 unless stated)
REQ-030 MSB-first transfer: start with parallel_in=0xA5, then 8 shift_en strobes with serial_in bits 0,0,1,1,1,1,0,0 -> serial_out 1,0,1,0,0,1,0,1; parallel_out=0x3C; done one cycle after the 8th strobe.
REQ-031 LSB-first transfer: load 0xA5 with lsb_first=1, serial_in=1 throughout -> serial_out 1,0,1,0,0,1,0,1; final parallel_out=0xFF; bit_count 8->0.
REQ-032 Manual modes: load 0x81, left with serial_in=0 -> 0x02; right with serial_in=1 -> 0x81; hold with shift_en=1 -> 0x81 unchanged.
REQ-033 Simultaneous events: start and shift_en in the same IDLE cycle -> loaded value unshifted, bit_count=8; start during XFER -> ignored; start in the done cycle -> new transfer begins.
REQ-034 Reset mid-transfer after 3 shifts -> all outputs 0, no done pulse, IDLE; then WIDTH=16 and WIDTH=2 smoke transfers complete in exactly 16 and 2 strobes.

Source files
------------

// File: rtl/shift_engine_pkg.sv
// Shared encodings for the shift engine: manual op codes and FSM states.
package shift_engine_pkg;

  // Manual register operations, also used internally to drive the core mux
  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_RIGHT = 2'b01;
  localparam logic [1:0] MODE_LEFT  = 2'b10;
  localparam logic [1:0] MODE_PLOAD = 2'b11;

  // Transfer FSM states
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_XFER = 1'b1;

endpackage

// File: rtl/shift_core.sv
// WIDTH-bit register with a hold/right/left/load mux, gated by en.
module shift_core
  import shift_engine_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] parallel_in,
  input  logic             serial_in,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] reg_q, reg_d;

  // Next register value: only an enabled op changes the contents
  always_comb begin
    reg_d = reg_q;
    if (en) begin
      case (op)
        MODE_RIGHT: reg_d = {serial_in, reg_q[WIDTH-1:1]};
        MODE_LEFT:  reg_d = {reg_q[WIDTH-2:0], serial_in};
        MODE_PLOAD: reg_d = parallel_in;
        default:    reg_d = reg_q;
      endcase
    end
  end

  // Register update with synchronous clear
  always_ff @(posedge clk) begin
    if (!rst_n) reg_q <= '0;
    else        reg_q <= reg_d;
  end

  assign q = reg_q;

endmodule

// File: rtl/shift_engine.sv
// Shift engine: manual shift register plus an automatic WIDTH-bit transfer
// sequencer (IDLE/XFER) with remaining-shift counter and done pulse.
module shift_engine
  import shift_engine_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       shift_en,
  input  logic [1:0]                 mode,
  input  logic [WIDTH-1:0]           parallel_in,
  input  logic                       serial_in,
  input  logic                       start,
  input  logic                       lsb_first,
  output logic [WIDTH-1:0]           parallel_out,
  output logic                       serial_out,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(WIDTH+1)-1:0] bit_count
);

  localparam int CW = $clog2(WIDTH+1);

  logic [0:0]    state_q, state_d;
  logic          dir_q, dir_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;
  logic          core_en;
  logic [1:0]    core_op;
  logic [WIDTH-1:0] core_q;

  shift_core #(.WIDTH(WIDTH)) u_core (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (core_en),
    .op          (core_op),
    .parallel_in (parallel_in),
    .serial_in   (serial_in),
    .q           (core_q)
  );

  // FSM: start wins over manual ops in IDLE; XFER shifts in the latched
  // direction on each strobe and ignores mode/start/lsb_first entirely
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    core_en = 1'b0;
    core_op = MODE_HOLD;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          core_en = 1'b1;
          core_op = MODE_PLOAD;
          dir_d   = lsb_first;
          cnt_d   = CW'(WIDTH);
          state_d = ST_XFER;
        end else begin
          core_en = shift_en;
          core_op = mode;
        end
      end
      default: begin
        if (shift_en) begin
          core_en = 1'b1;
          core_op = dir_q ? MODE_RIGHT : MODE_LEFT;
          cnt_d   = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
    endcase
  end

  // Control state; reset aborts any transfer without a done pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      dir_q   <= 1'b0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign parallel_out = core_q;
  assign serial_out   = dir_q ? core_q[0] : core_q[WIDTH-1];
  assign busy         = (state_q == ST_XFER);
  assign done         = done_q;
  assign bit_count    = cnt_q;

endmodule

// File: tb/tb_shift_engine.sv
// Directed bench for shift_engine: WIDTH=8 main instance plus WIDTH=16/2 smoke.
module tb_shift_engine;
  import shift_engine_pkg::*;

  logic clk = 1'b0;
  logic rst_n, shift_en, start, lsb_first, serial_in;
  logic [1:0] mode;
  logic [7:0]  pin8;  logic [7:0]  po8;  logic so8,  busy8,  done8;  logic [3:0] bc8;
  logic [15:0] pin16; logic [15:0] po16; logic so16, busy16, done16; logic [4:0] bc16;
  logic [1:0]  pin2;  logic [1:0]  po2;  logic so2,  busy2,  done2;  logic [1:0] bc2;

  int pass = 0;
  int total = 0;

  always #5 clk = ~clk;

  shift_engine #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .shift_en(shift_en), .mode(mode), .parallel_in(pin8),
    .serial_in(serial_in), .start(start), .lsb_first(lsb_first), .parallel_out(po8),
    .serial_out(so8), .busy(busy8), .done(done8), .bit_count(bc8));

  shift_engine #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .shift_en(shift_en), .mode(mode), .parallel_in(pin16),
    .serial_in(serial_in), .start(start), .lsb_first(lsb_first), .parallel_out(po16),
    .serial_out(so16), .busy(busy16), .done(done16), .bit_count(bc16));

  shift_engine #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .shift_en(shift_en), .mode(mode), .parallel_in(pin2),
    .serial_in(serial_in), .start(start), .lsb_first(lsb_first), .parallel_out(po2),
    .serial_out(so2), .busy(busy2), .done(done2), .bit_count(bc2));

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic strobe(input logic si);
    shift_en = 1'b1; serial_in = si;
    step();
    shift_en = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; shift_en = 1'b1; mode = MODE_PLOAD; pin8 = 8'hFF;
    step(); step();
    total++; if (po8 !== 8'h00) $display("FAIL reset_po: got %h want 00", po8); else pass++;
    total++; if (so8 !== 1'b0) $display("FAIL reset_so: got %b want 0", so8); else pass++;
    total++; if (busy8 !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy8); else pass++;
    total++; if (done8 !== 1'b0) $display("FAIL reset_done: got %b want 0", done8); else pass++;
    total++; if (bc8 !== 4'd0) $display("FAIL reset_bc: got %0d want 0", bc8); else pass++;
    start = 1'b0; shift_en = 1'b0; mode = MODE_HOLD; rst_n = 1'b1;
    step();
    total++; if (busy8 !== 1'b0 || po8 !== 8'h00) $display("FAIL reset_release: busy %b po %h want 0/00", busy8, po8); else pass++;
  endtask

  task automatic test_msb_first();
    logic [7:0] si_seq, so_seq;
    si_seq = 8'b00111100; so_seq = 8'b10100101;
    pin8 = 8'hA5; lsb_first = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    total++; if (po8 !== 8'hA5 || busy8 !== 1'b1 || bc8 !== 4'd8) $display("FAIL msb_load: po %h busy %b bc %0d want a5/1/8", po8, busy8, bc8); else pass++;
    for (int i = 0; i < 8; i++) begin
      total++; if (so8 !== so_seq[7-i]) $display("FAIL msb_so[%0d]: got %b want %b", i, so8, so_seq[7-i]); else pass++;
      total++; if (done8 !== 1'b0 || busy8 !== 1'b1) $display("FAIL msb_busy[%0d]: done %b busy %b want 0/1", i, done8, busy8); else pass++;
      strobe(si_seq[7-i]);
      if (i == 2 || i == 5) begin
        step();
        total++; if (bc8 !== 4'(7-i)) $display("FAIL msb_gap_bc[%0d]: got %0d want %0d", i, bc8, 7-i); else pass++;
      end
    end
    total++; if (done8 !== 1'b1 || busy8 !== 1'b0) $display("FAIL msb_done: done %b busy %b want 1/0", done8, busy8); else pass++;
    total++; if (po8 !== 8'h3C) $display("FAIL msb_po: got %h want 3c", po8); else pass++;
    total++; if (bc8 !== 4'd0) $display("FAIL msb_bc: got %0d want 0", bc8); else pass++;
    step();
    total++; if (done8 !== 1'b0) $display("FAIL msb_done_pulse: got %b want 0", done8); else pass++;
  endtask

  task automatic test_lsb_first();
    logic [7:0] so_seq;
    so_seq = 8'b10100101;
    pin8 = 8'hA5; lsb_first = 1'b1; start = 1'b1;
    step();
    start = 1'b0; lsb_first = 1'b0;
    for (int i = 0; i < 8; i++) begin
      total++; if (bc8 !== 4'(8-i)) $display("FAIL lsb_bc[%0d]: got %0d want %0d", i, bc8, 8-i); else pass++;
      total++; if (so8 !== so_seq[7-i]) $display("FAIL lsb_so[%0d]: got %b want %b", i, so8, so_seq[7-i]); else pass++;
      strobe(1'b1);
    end
    total++; if (po8 !== 8'hFF || bc8 !== 4'd0) $display("FAIL lsb_end: po %h bc %0d want ff/0", po8, bc8); else pass++;
    total++; if (done8 !== 1'b1 || busy8 !== 1'b0) $display("FAIL lsb_done: done %b busy %b want 1/0", done8, busy8); else pass++;
    step();
  endtask

  task automatic test_manual();
    mode = MODE_PLOAD; pin8 = 8'h81; strobe(1'b0);
    total++; if (po8 !== 8'h81) $display("FAIL man_load: got %h want 81", po8); else pass++;
    mode = MODE_LEFT; strobe(1'b0);
    total++; if (po8 !== 8'h02) $display("FAIL man_left: got %h want 02", po8); else pass++;
    mode = MODE_RIGHT; strobe(1'b1);
    total++; if (po8 !== 8'h81) $display("FAIL man_right: got %h want 81", po8); else pass++;
    mode = MODE_HOLD; strobe(1'b0);
    total++; if (po8 !== 8'h81) $display("FAIL man_hold: got %h want 81", po8); else pass++;
    mode = MODE_LEFT; serial_in = 1'b1; step();
    total++; if (po8 !== 8'h81 || busy8 !== 1'b0) $display("FAIL man_no_strobe: po %h busy %b want 81/0", po8, busy8); else pass++;
    // direction bit still 1 from the LSB-first transfer: serial_out tracks reg[0]
    mode = MODE_PLOAD; pin8 = 8'h01; strobe(1'b0);
    total++; if (so8 !== 1'b1) $display("FAIL man_dir: got %b want 1", so8); else pass++;
    mode = MODE_HOLD;
  endtask

  task automatic test_back_to_back();
    pin8 = 8'h5A; lsb_first = 1'b0; start = 1'b1; shift_en = 1'b1; mode = MODE_LEFT; serial_in = 1'b1;
    step();
    total++; if (po8 !== 8'h5A || bc8 !== 4'd8 || busy8 !== 1'b1) $display("FAIL sim_start: po %h bc %0d busy %b want 5a/8/1", po8, bc8, busy8); else pass++;
    shift_en = 1'b0; pin8 = 8'hFF; lsb_first = 1'b1; mode = MODE_PLOAD;
    step();
    total++; if (po8 !== 8'h5A || bc8 !== 4'd8) $display("FAIL xfer_start_ign: po %h bc %0d want 5a/8", po8, bc8); else pass++;
    mode = MODE_RIGHT; strobe(1'b0);
    total++; if (po8 !== 8'hB4 || bc8 !== 4'd7) $display("FAIL xfer_mode_ign: po %h bc %0d want b4/7", po8, bc8); else pass++;
    for (int i = 0; i < 7; i++) strobe(1'b0);
    total++; if (done8 !== 1'b1 || po8 !== 8'h00) $display("FAIL b2b_done1: done %b po %h want 1/00", done8, po8); else pass++;
    pin8 = 8'hC3; lsb_first = 1'b0;
    step();
    start = 1'b0;
    total++; if (busy8 !== 1'b1 || bc8 !== 4'd8 || po8 !== 8'hC3) $display("FAIL b2b_start: busy %b bc %0d po %h want 1/8/c3", busy8, bc8, po8); else pass++;
    for (int i = 0; i < 8; i++) strobe(1'b0);
    total++; if (done8 !== 1'b1 || po8 !== 8'h00) $display("FAIL b2b_done2: done %b po %h want 1/00", done8, po8); else pass++;
    step();
    total++; if (busy8 !== 1'b0 || done8 !== 1'b0) $display("FAIL b2b_no_queue: busy %b done %b want 0/0", busy8, done8); else pass++;
    mode = MODE_HOLD;
  endtask

  task automatic test_reset_mid();
    pin8 = 8'hA5; lsb_first = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 3; i++) strobe(1'b1);
    total++; if (bc8 !== 4'd5) $display("FAIL rst_mid_pre: bc %0d want 5", bc8); else pass++;
    rst_n = 1'b0; start = 1'b1; shift_en = 1'b1;
    step();
    start = 1'b0; shift_en = 1'b0;
    total++; if (po8 !== 8'h00 || so8 !== 1'b0 || busy8 !== 1'b0 || done8 !== 1'b0 || bc8 !== 4'd0)
      $display("FAIL rst_mid: po %h so %b busy %b done %b bc %0d want all 0", po8, so8, busy8, done8, bc8); else pass++;
    rst_n = 1'b1;
    step();
    total++; if (done8 !== 1'b0 || busy8 !== 1'b0) $display("FAIL rst_mid_after: done %b busy %b want 0/0", done8, busy8); else pass++;
  endtask

  task automatic test_widths();
    pin16 = 16'h1234; pin2 = 2'b10; pin8 = 8'h00; lsb_first = 1'b0; mode = MODE_HOLD; start = 1'b1;
    step();
    start = 1'b0;
    total++; if (bc16 !== 5'd16 || bc2 !== 2'd2) $display("FAIL w_load_bc: bc16 %0d bc2 %0d want 16/2", bc16, bc2); else pass++;
    strobe(1'b1);
    total++; if (busy2 !== 1'b1 || done2 !== 1'b0) $display("FAIL w2_mid: busy %b done %b want 1/0", busy2, done2); else pass++;
    strobe(1'b1);
    total++; if (done2 !== 1'b1 || busy2 !== 1'b0 || po2 !== 2'b11) $display("FAIL w2_done: done %b busy %b po %b want 1/0/11", done2, busy2, po2); else pass++;
    total++; if (bc16 !== 5'd14 || busy16 !== 1'b1) $display("FAIL w16_mid: bc %0d busy %b want 14/1", bc16, busy16); else pass++;
    for (int i = 0; i < 13; i++) strobe(1'b1);
    total++; if (busy16 !== 1'b1 || done16 !== 1'b0 || bc16 !== 5'd1) $display("FAIL w16_pre: busy %b done %b bc %0d want 1/0/1", busy16, done16, bc16); else pass++;
    strobe(1'b1);
    total++; if (done16 !== 1'b1 || busy16 !== 1'b0 || po16 !== 16'hFFFF) $display("FAIL w16_done: done %b busy %b po %h want 1/0/ffff", done16, busy16, po16); else pass++;
    step();
  endtask

  initial begin
    rst_n = 1'b0; shift_en = 1'b0; start = 1'b0; lsb_first = 1'b0; serial_in = 1'b0;
    mode = MODE_HOLD; pin8 = '0; pin16 = '0; pin2 = '0;
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_manual();
    test_back_to_back();
    test_reset_mid();
    test_widths();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
